led_trail_fade: RTL and testbench
=================================

# led_trail_fade

Downstream consumer of the 16-bit running-light pattern on the nvboard LED bank. Takes the raw one-hot/shift pattern and drives the physical LEDs with a fading "comet trail". Any LED that is on in the input pattern is driven at full brightness. Once the input drops, that LED decays step-by-step through PWM brightness levels to off.

## Interface

Parameters:
- WIDTH, 16, number of LEDs in the input pattern and on the output.
- PWM_BITS, 4, brightness resolution; MAX = 2^PWM_BITS-1; legal range 2..8.
- DECAY_DIV, 1000000, clock cycles per decay step; legal minimum 2.

Ports:
- clk, input, 1, single system clock, rising-edge.
- rst_n, input, 1, synchronous, active-high reset: asserted when 1, sampled on the rising edge of clk.
- led_in, input, WIDTH, LED pattern from the upstream running-light stage.
- led_out, output, WIDTH, registered PWM drive to the LEDs.
- decay_tick, output, 1, high for the single cycle in which a decay step is applied.

## Operation

- Input stage: led_q <= led_in every cycle. This is a single register stage, with no synchronizer beyond it.
- Decay divider dcnt:
  - Width is clog2(DECAY_DIV).
  - Counts 0..DECAY_DIV-1, then wraps to 0.
  - decay_tick = (dcnt == DECAY_DIV-1), decoded from the register.
- PWM counter pcnt:
  - PWM_BITS wide, free-running.
  - Wraps MAX -> 0.
- Per-LED brightness register level[i] (PWM_BITS bits), updated each cycle with this priority:
  - led_q[i]==1 -> level[i] <= MAX. Load wins over decay when both occur in the same cycle.
  - else if decay_tick and level[i]!=0 -> level[i] <= level[i]-1.
  - else hold. level[i] saturates at 0 and never wraps below 0.
- Output compare, registered:
  - led_out[i] <= 1 if level[i]==MAX.
  - else led_out[i] <= (level[i] > pcnt).
  - Resulting duty: MAX = 100%, L = L/2^PWM_BITS, 0 = 0%.
- All LEDs share dcnt and pcnt, so LEDs at equal level produce identical waveforms.
- Reset while rst_n==1 forces led_q=0, level[*]=0, dcnt=0, pcnt=0, led_out=0. decay_tick is therefore 0 during and immediately after reset. All counters restart from 0 on the first cycle after release.

## Timing

- Load latency:
  - led_in[i]=1 sampled at edge k -> level[i]=MAX after edge k+1 -> led_out[i]=1 after edge k+2.
  - A one-cycle input pulse is sufficient to trigger the full trail.
- Decay period: one level step per DECAY_DIV cycles. A full fade takes MAX*DECAY_DIV cycles after the last load, ±DECAY_DIV depending on divider phase.
- The first decay step after a load occurs at the next decay_tick. Divider phase is never reset by loads.
- After decay, led_out follows the new level with one cycle of register latency.
- Held input: level stays MAX, so led_out stays constantly 1 with no flicker.
- Reset mid-fade: takes effect at the next edge. No partial state survives, and there is no output glitch beyond that edge.

## Test plan

All scenarios use PWM_BITS=4, DECAY_DIV=4, WIDTH=16.

- **Reset:** rst_n=1 for 3 cycles with led_in=0xFFFF -> led_out=0x0000 and decay_tick=0 throughout. Release rst_n -> led_out=0xFFFF exactly 2 edges after the first sampled edge.
- **Single pulse:** led_in=0x0001 for 1 cycle, then 0 ->
  - led_out[0] high continuously until the first tick.
  - At level 14: low for exactly 2 of every 16 cycles (pcnt 14, 15).
  - Level reaches 0 after 15 ticks (≤64 cycles); led_out[0]=0 thereafter.
  - led_out[15:1]=0 throughout.
- **Held input:** led_in=0x8000 held for 200 cycles -> led_out[15]=1 every cycle; decay_tick still pulses every 4th cycle.
- **Simultaneous load and decay:** bring level[3] to 5, then assert led_in[3] so that led_q[3]=1 in the same cycle decay_tick=1 -> level[3]=15, not 4; led_out[3] constant 1 afterward.
- **Shifting pattern (upstream emulation):** led_in=0x0001, 0x0002, 0x0004, 0x0008, each for 4 cycles, then 0 -> at the end, level[3..0] is strictly non-increasing toward bit 0. Measured duty over 16 cycles matches level/16 for each bit, with bit 3 at the highest level.
- **Reset mid-fade:** with several levels nonzero, assert rst_n=1 for 1 cycle -> next cycle led_out=0x0000, dcnt=0, pcnt=0; no LED lights again until led_in reloads it.

Source files
------------

// File: rtl/led_trail_fade.sv
// Comet-trail driver for the LED bank: any lit input LED snaps to full
// brightness, then fades out one PWM level per decay step.
module led_trail_fade #(
    parameter int WIDTH     = 16,
    parameter int PWM_BITS  = 4,
    parameter int DECAY_DIV = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] led_in,
    output logic [WIDTH-1:0] led_out,
    output logic             decay_tick
);

    localparam int DW = $clog2(DECAY_DIV);
    localparam logic [DW-1:0] DLAST = DW'(DECAY_DIV - 1);
    localparam logic [PWM_BITS-1:0] MAX = '1;

    logic [WIDTH-1:0]    led_q;
    logic [DW-1:0]       dcnt;
    logic [PWM_BITS-1:0] pcnt;
    logic [PWM_BITS-1:0] level [WIDTH];

    assign decay_tick = (dcnt == DLAST);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            led_q <= '0;
            dcnt  <= '0;
            pcnt  <= '0;
        end else begin
            led_q <= led_in;
            dcnt  <= decay_tick ? '0 : dcnt + DW'(1);
            pcnt  <= pcnt + PWM_BITS'(1);
        end
    end

    // Load beats decay; level saturates at zero.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            led_out <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                level[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (led_q[i]) begin
                    level[i] <= MAX;
                end else if (decay_tick && level[i] != '0) begin
                    level[i] <= level[i] - PWM_BITS'(1);
                end
                led_out[i] <= (level[i] == MAX) || (level[i] > pcnt);
            end
        end
    end

endmodule

// File: tb/tb_led_trail_fade.sv
// Directed bench for led_trail_fade with WIDTH=16, PWM_BITS=4, DECAY_DIV=4.
// Edge numbering restarts at 1 on the first edge after reset release.
module tb_led_trail_fade;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] led_in;
    logic [15:0] led_out;
    logic        decay_tick;

    int vec = 0;
    int err = 0;

    led_trail_fade #(
        .WIDTH(16),
        .PWM_BITS(4),
        .DECAY_DIV(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .led_in(led_in),
        .led_out(led_out),
        .decay_tick(decay_tick)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n  = 1'b1;
        led_in = '0;
        repeat (2) step;
        rst_n = 1'b0;
    endtask

    task automatic test_reset;
        rst_n  = 1'b1;
        led_in = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            step;
            vec++;
            if (led_out !== 16'h0000 || decay_tick !== 1'b0) begin
                err++;
                $display("FAIL reset_hold c=%0d out=%h tick=%b want 0000/0",
                         c, led_out, decay_tick);
            end
        end
        rst_n = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            step;
            vec++;
            if (led_out !== ((n == 3) ? 16'hFFFF : 16'h0000)) begin
                err++;
                $display("FAIL reset_release n=%0d out=%h want %h",
                         n, led_out, (n == 3) ? 16'hFFFF : 16'h0000);
            end
        end
        vec++;
        if (decay_tick !== 1'b1) begin
            err++;
            $display("FAIL reset_first_tick got=%b want 1", decay_tick);
        end
    endtask

    task automatic test_single_pulse;
        int m;
        int lvl;
        logic e;
        apply_reset;
        led_in = 16'h0001;
        for (int n = 1; n <= 80; n++) begin
            step;
            if (n == 1) led_in = '0;
            m   = n - 1;
            lvl = (m < 2) ? 0 : 15 - m / 4;
            if (lvl < 0) lvl = 0;
            e = (lvl == 15) || (lvl > (m % 16));
            vec++;
            if (led_out !== {15'b0, e}) begin
                err++;
                $display("FAIL pulse n=%0d out=%h want %h",
                         n, led_out, {15'b0, e});
            end
            vec++;
            if (decay_tick !== ((n % 4) == 3)) begin
                err++;
                $display("FAIL pulse_tick n=%0d got=%b want %b",
                         n, decay_tick, (n % 4) == 3);
            end
        end
    endtask

    task automatic test_held;
        logic [15:0] w;
        apply_reset;
        led_in = 16'h8000;
        for (int n = 1; n <= 200; n++) begin
            step;
            w = (n >= 3) ? 16'h8000 : 16'h0000;
            vec++;
            if (led_out !== w || decay_tick !== ((n % 4) == 3)) begin
                err++;
                $display("FAIL held n=%0d out=%h tick=%b want %h/%b",
                         n, led_out, decay_tick, w, (n % 4) == 3);
            end
        end
    endtask

    task automatic test_load_vs_decay;
        apply_reset;
        led_in = 16'h0008;
        for (int n = 1; n <= 48; n++) begin
            step;
            if (n == 1)  led_in = '0;
            if (n == 42) led_in = 16'h0008;
            if (n == 43) begin
                led_in = '0;
                vec++;
                if (decay_tick !== 1'b1) begin
                    err++;
                    $display("FAIL ld_tick n=43 got=%b want 1", decay_tick);
                end
            end
            if (n == 44) begin
                vec++;
                if (led_out !== 16'h0000) begin
                    err++;
                    $display("FAIL ld_pre n=44 out=%h want 0000", led_out);
                end
            end
            if (n >= 45) begin
                vec++;
                if (led_out !== 16'h0008) begin
                    err++;
                    $display("FAIL ld_win n=%0d out=%h want 0008", n, led_out);
                end
            end
        end
    endtask

    task automatic test_shift_and_midreset;
        int cnt [4];
        int want_cnt [4];
        int want_lvl [4];
        want_cnt = '{10, 11, 12, 12};
        want_lvl = '{11, 12, 13, 14};
        cnt = '{0, 0, 0, 0};
        apply_reset;
        led_in = 16'h0001;
        for (int n = 1; n <= 36; n++) begin
            step;
            led_in = (n < 16) ? (16'h0001 << (n / 4)) : 16'h0000;
            if (n == 20) begin
                for (int b = 0; b < 4; b++) begin
                    vec++;
                    if (dut.level[b] !== 4'(want_lvl[b])) begin
                        err++;
                        $display("FAIL shift_level b=%0d got=%0d want %0d",
                                 b, dut.level[b], want_lvl[b]);
                    end
                end
            end
            if (n >= 21) begin
                for (int b = 0; b < 4; b++) cnt[b] += int'(led_out[b]);
                vec++;
                if (led_out[15:4] !== 12'h000) begin
                    err++;
                    $display("FAIL shift_upper n=%0d out=%h want 0 above bit3",
                             n, led_out);
                end
            end
        end
        for (int b = 0; b < 4; b++) begin
            vec++;
            if (cnt[b] != want_cnt[b]) begin
                err++;
                $display("FAIL shift_duty b=%0d got=%0d want %0d",
                         b, cnt[b], want_cnt[b]);
            end
        end
        rst_n = 1'b1;
        step;
        vec++;
        if (led_out !== 16'h0000 || dut.dcnt !== 2'd0 ||
            dut.pcnt !== 4'd0 || decay_tick !== 1'b0) begin
            err++;
            $display("FAIL midreset out=%h dcnt=%0d pcnt=%0d tick=%b want 0",
                     led_out, dut.dcnt, dut.pcnt, decay_tick);
        end
        rst_n = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            step;
            vec++;
            if (led_out !== 16'h0000) begin
                err++;
                $display("FAIL post_reset n=%0d out=%h want 0000", n, led_out);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        led_in = '0;
        test_reset;
        test_single_pulse;
        test_held;
        test_load_vs_decay;
        test_shift_and_midreset;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
